// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store store buffer.
package lsu_pkg;
    localparam int SB_DATA_W = 16;
    localparam int SB_ADDR_W = 16;
    localparam int SB_NB     = SB_DATA_W / 8;
    localparam logic [1:0] TYPE_STORE = 2'b11;

    typedef struct packed {
        logic [SB_DATA_W-1:0] data;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_NB-1:0]     strb;
    } sb_entry_t;
endpackage

// File: rtl/sb_fwd_lane.sv
// One byte lane of store-to-load forwarding: picks the youngest matching entry,
// scanning from ptr_old (oldest) so later hits override earlier ones.
module sb_fwd_lane #(
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic [DEPTH-1:0]   match_i,
    input  logic [DEPTH*8-1:0] bytes_i,
    input  logic [PW-1:0]      ptr_old_i,
    output logic               hit_o,
    output logic [7:0]         byte_o
);
    logic [PW-1:0] idx;

    always_comb begin
        hit_o  = 1'b0;
        byte_o = '0;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = ptr_old_i + PW'(i);
            if (match_i[idx]) begin
                hit_o  = 1'b1;
                byte_o = bytes_i[{idx, 3'b000} +: 8];
            end
        end
    end
endmodule

// File: rtl/store_buffer_mem.sv
// In-order speculative store buffer in front of a data memory; stores drain on ROB
// retirement, loads forward per byte from the youngest matching buffered store.
module store_buffer_mem
    import lsu_pkg::*;
#(
    parameter int DATA_W    = SB_DATA_W,
    parameter int ADDR_W    = SB_ADDR_W,
    parameter int MEM_DEPTH = 256,
    parameter int SB_DEPTH  = 16,
    parameter int RET_W     = 3,
    parameter int TAG_W     = 5,
    parameter int PREG_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          freeze_back,
    input  logic                          valid_ls,
    input  logic                          mode,
    input  logic [DATA_W-1:0]             busX,
    input  logic [ADDR_W-1:0]             Addr,
    input  logic [DATA_W/8-1:0]           strb,
    input  logic [TAG_W-1:0]              tag_ROB_ls,
    input  logic [PREG_W-1:0]             Px,
    output logic                          valid_Result_ls,
    output logic                          mode_ls,
    output logic [TAG_W-1:0]              tag_ROB_Result_ls,
    output logic [DATA_W-1:0]             Result_ls,
    output logic [PREG_W-1:0]             Pw_Result_ls,
    output logic                          full_sb,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    input  logic [RET_W-1:0]              ready_ret,
    input  logic [RET_W-1:0]              excep_ret,
    input  logic [2*RET_W-1:0]            Type_ret
);
    localparam int NB = DATA_W / 8;
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = $clog2(SB_DEPTH + 1);
    localparam int MW = $clog2(MEM_DEPTH);
    localparam int NW = $clog2(RET_W + 1);

    sb_entry_t           ent_q [SB_DEPTH];
    logic [SB_DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]       ptr_old_q, ptr_young_q;
    logic [CW-1:0]       count_q;
    logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
    logic [NW-1:0]       ret_n;
    logic [PW-1:0]       ret_idx [RET_W];
    logic                accept;
    logic                ret_go;
    logic [DATA_W-1:0]   ld_data;

    // Retiring stores are the leading run of ready, exception-free lanes.
    always_comb begin
        ret_n  = '0;
        ret_go = 1'b1;
        for (int k = 0; k < RET_W; k++) begin
            ret_idx[k] = ptr_old_q + PW'(k);
            if (ret_go && ready_ret[k] && !excep_ret[k]) begin
                if (Type_ret[2*k +: 2] == TYPE_STORE) ret_n = ret_n + NW'(1);
            end else begin
                ret_go = 1'b0;
            end
        end
    end

    assign full_sb  = (count_q == CW'(SB_DEPTH));
    assign sb_count = count_q;
    assign accept   = valid_ls && !mode && !freeze_back && !flush && (!full_sb || ret_n != '0);

    always_comb begin
        vld_d = vld_q;
        for (int k = 0; k < RET_W; k++)
            if (k < int'(ret_n)) vld_d[ret_idx[k]] = 1'b0;
        if (flush)       vld_d = '0;
        else if (accept) vld_d[ptr_young_q] = 1'b1;
    end

    for (genvar b = 0; b < NB; b++) begin : g_lane
        logic [SB_DEPTH-1:0]   fwd_match;
        logic [SB_DEPTH*8-1:0] fwd_bytes;
        logic                  fwd_hit;
        logic [7:0]            fwd_byte;

        always_comb begin
            fwd_match = '0;
            fwd_bytes = '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                fwd_match[i]       = vld_q[i] && (ent_q[i].addr == Addr) && ent_q[i].strb[b];
                fwd_bytes[i*8 +: 8] = ent_q[i].data[b*8 +: 8];
            end
        end

        sb_fwd_lane #(.DEPTH(SB_DEPTH), .PW(PW)) u_fwd (
            .match_i   (fwd_match),
            .bytes_i   (fwd_bytes),
            .ptr_old_i (ptr_old_q),
            .hit_o     (fwd_hit),
            .byte_o    (fwd_byte)
        );

        assign ld_data[b*8 +: 8] = fwd_hit ? fwd_byte : mem_q[Addr[MW-1:0]][b*8 +: 8];
    end

    // Younger retiring entries are written later in the loop so they win per byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            ptr_old_q   <= '0;
            ptr_young_q <= '0;
            count_q     <= '0;
            for (int i = 0; i < SB_DEPTH; i++) ent_q[i] <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int k = 0; k < RET_W; k++) begin
                if (k < int'(ret_n)) begin
                    for (int b = 0; b < NB; b++)
                        if (ent_q[ret_idx[k]].strb[b])
                            mem_q[ent_q[ret_idx[k]].addr[MW-1:0]][b*8 +: 8] <= ent_q[ret_idx[k]].data[b*8 +: 8];
                end
            end
            vld_q     <= vld_d;
            ptr_old_q <= ptr_old_q + PW'(ret_n);
            if (flush) begin
                ptr_young_q <= ptr_old_q + PW'(ret_n);
                count_q     <= '0;
            end else begin
                if (accept) begin
                    ent_q[ptr_young_q] <= {busX, Addr, strb};
                    ptr_young_q        <= ptr_young_q + PW'(1);
                end
                count_q <= count_q + CW'(accept) - CW'(ret_n);
            end
        end
    end

    // valid_Result_ls is a one-cycle-later echo of valid_ls; there is no ready, a dropped store simply reports 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_Result_ls   <= 1'b0;
            mode_ls           <= 1'b0;
            tag_ROB_Result_ls <= '0;
            Result_ls         <= '0;
            Pw_Result_ls      <= '0;
        end else if (flush) begin
            valid_Result_ls   <= 1'b0;
            mode_ls           <= 1'b0;
            tag_ROB_Result_ls <= '0;
            Result_ls         <= '0;
            Pw_Result_ls      <= '0;
        end else if (!freeze_back) begin
            valid_Result_ls   <= valid_ls && (mode || accept);
            mode_ls           <= mode;
            tag_ROB_Result_ls <= tag_ROB_ls;
            Result_ls         <= ld_data;
            Pw_Result_ls      <= Px;
        end
    end

    a_ret_le_count: assert property (@(posedge clk) disable iff (rst) CW'(ret_n) <= count_q);
endmodule

// File: tb/tb_store_buffer_mem.sv
// Randomized and directed bench for store_buffer_mem against a queue-based reference model.
module tb_store_buffer_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, freeze_back = 1'b0, valid_ls = 1'b0, mode = 1'b0;
    logic [15:0] busX = '0, Addr = '0;
    logic [1:0]  strb = '0;
    logic [4:0]  tag_ROB_ls = '0, Px = '0;
    logic        valid_Result_ls, mode_ls, full_sb;
    logic [4:0]  tag_ROB_Result_ls, Pw_Result_ls, sb_count;
    logic [15:0] Result_ls;
    logic [2:0]  ready_ret = '0, excep_ret = '0;
    logic [5:0]  Type_ret = '0;

    store_buffer_mem dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_back(freeze_back),
        .valid_ls(valid_ls), .mode(mode), .busX(busX), .Addr(Addr), .strb(strb),
        .tag_ROB_ls(tag_ROB_ls), .Px(Px),
        .valid_Result_ls(valid_Result_ls), .mode_ls(mode_ls),
        .tag_ROB_Result_ls(tag_ROB_Result_ls), .Result_ls(Result_ls),
        .Pw_Result_ls(Pw_Result_ls), .full_sb(full_sb), .sb_count(sb_count),
        .ready_ret(ready_ret), .excep_ret(excep_ret), .Type_ret(Type_ret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic [15:0] addr;
        logic [1:0]  strb;
    } ent_t;

    typedef struct packed {
        logic        v;
        logic        md;
        logic [4:0]  tag;
        logic [15:0] data;
        logic [4:0]  pw;
    } out_t;

    ent_t        sbm[$];
    logic [15:0] memm [256];
    out_t        exp_q[$];
    out_t        last_out;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int calc_n(input logic [2:0] r, input logic [2:0] e, input logic [5:0] t);
        int n = 0;
        for (int k = 0; k < 3; k++) begin
            if (!(r[k] && !e[k])) break;
            if (t[2*k +: 2] == 2'b11) n++;
        end
        return n;
    endfunction

    function automatic logic [15:0] model_load(input logic [15:0] a);
        logic [15:0] d = memm[a[7:0]];
        foreach (sbm[i])
            for (int b = 0; b < 2; b++)
                if (sbm[i].addr == a && sbm[i].strb[b]) d[b*8 +: 8] = sbm[i].data[b*8 +: 8];
        return d;
    endfunction

    function automatic void model_reset();
        sbm.delete();
        exp_q.delete();
        last_out = '0;
        for (int i = 0; i < 256; i++) memm[i] = '0;
    endfunction

    task automatic step(input logic v, input logic md, input logic [15:0] d, input logic [15:0] a,
                        input logic [1:0] s, input logic fl, input logic fz,
                        input logic [2:0] r, input logic [2:0] e, input logic [5:0] t);
        int   n;
        logic full, acc;
        out_t o;
        ent_t en;
        logic [4:0] tg, px;
        tg   = 5'($urandom);
        px   = 5'($urandom);
        n    = calc_n(r, e, t);
        full = (sbm.size() == 16);
        acc  = v && !md && !fz && !fl && (!full || n > 0);
        o.v = v && (md || acc); o.md = md; o.tag = tg; o.data = model_load(a); o.pw = px;
        if (fl) last_out = '0;
        else if (!fz) last_out = o;
        if (!fl && last_out.v) exp_q.push_back(last_out);
        for (int k = 0; k < n; k++) begin
            en = sbm.pop_front();
            for (int b = 0; b < 2; b++)
                if (en.strb[b]) memm[en.addr[7:0]][b*8 +: 8] = en.data[b*8 +: 8];
        end
        if (fl) sbm.delete();
        else if (acc) begin
            en.data = d; en.addr = a; en.strb = s;
            sbm.push_back(en);
        end
        valid_ls = v; mode = md; busX = d; Addr = a; strb = s; tag_ROB_ls = tg; Px = px;
        flush = fl; freeze_back = fz; ready_ret = r; excep_ret = e; Type_ret = t;
        @(posedge clk);
        #1;
        valid_ls = 1'b0; flush = 1'b0; freeze_back = 1'b0; ready_ret = '0; excep_ret = '0;
        chk("sb_count", 32'(sb_count), 32'(sbm.size()));
        chk("full_sb", 32'(full_sb), 32'(sbm.size() == 16));
    endtask

    task automatic st(input logic [15:0] d, input logic [15:0] a, input logic [1:0] s, input int k);
        step(1'b1, 1'b0, d, a, s, 1'b0, 1'b0, 3'((1 << k) - 1), 3'b000, 6'h3f);
    endtask

    task automatic ld(input logic [15:0] a);
        step(1'b1, 1'b1, 16'h0, a, 2'b00, 1'b0, 1'b0, 3'b000, 3'b000, 6'h00);
    endtask

    task automatic idle_ret(input int k);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 3'((1 << k) - 1), 3'b000, 6'h3f);
    endtask

    task automatic ret_all();
        while (sbm.size() > 0) idle_ret(sbm.size() > 3 ? 3 : sbm.size());
    endtask

    task automatic chk_zero_outputs(input string tagname);
        chk({tagname, "_valid"}, 32'(valid_Result_ls), 0);
        chk({tagname, "_mode"}, 32'(mode_ls), 0);
        chk({tagname, "_tag"}, 32'(tag_ROB_Result_ls), 0);
        chk({tagname, "_result"}, 32'(Result_ls), 0);
        chk({tagname, "_pw"}, 32'(Pw_Result_ls), 0);
        chk({tagname, "_count"}, 32'(sb_count), 0);
        chk({tagname, "_full"}, 32'(full_sb), 0);
    endtask

    always @(negedge clk) begin : monitor
        out_t e;
        if (!rst && valid_Result_ls) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: valid_Result_ls=1 tag=%0d with nothing expected", tag_ROB_Result_ls);
            end else begin
                e = exp_q.pop_front();
                chk("mon_mode", 32'(mode_ls), 32'(e.md));
                chk("mon_tag", 32'(tag_ROB_Result_ls), 32'(e.tag));
                chk("mon_pw", 32'(Pw_Result_ls), 32'(e.pw));
                if (e.md) chk("mon_load_data", 32'(Result_ls), 32'(e.data));
            end
        end
    end

    logic [15:0] addr_tab [6] = '{16'h0010, 16'h0011, 16'h0020, 16'h0021, 16'h0110, 16'h0040};

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // forwarding from two overlapping stores
        st(16'h1234, 16'h0010, 2'b11, 0);
        st(16'hAB00, 16'h0010, 2'b10, 0);
        ld(16'h0010);
        chk("fwd_data", 32'(Result_ls), 32'h0000AB34);
        chk("fwd_valid", 32'(valid_Result_ls), 1);
        idle_ret(2);

        // partial hit over memory contents
        st(16'h5500, 16'h0020, 2'b11, 0);
        idle_ret(1);
        st(16'h00CD, 16'h0020, 2'b01, 0);
        ld(16'h0020);
        chk("partial_data", 32'(Result_ls), 32'h000055CD);

        // retire prefix stops at the excepting lane
        st(16'h1111, 16'h0021, 2'b11, 0);
        st(16'h2222, 16'h0011, 2'b11, 0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 3'b111, 3'b010, 6'h3f);
        chk("prefix_count", 32'(sb_count), 2);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 1'b0, 3'b000, 3'b000, 6'h00);
        ld(16'h0021);
        chk("prefix_unretired", 32'(Result_ls), 32'h0);
        ld(16'h0020);
        chk("prefix_retired", 32'(Result_ls), 32'h000055CD);

        // reset in the middle of traffic
        for (int i = 0; i < 5; i++) st(16'(16'h0A00 + i), 16'h0010, 2'b11, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        ld(16'h0010);
        chk("midreset_load", 32'(Result_ls), 32'h0);

        // full buffer: drop without retire, accept with retire
        for (int i = 0; i < 16; i++) st(16'($urandom), 16'(16'h0030 + i), 2'b11, 0);
        chk("full_set", 32'(full_sb), 1);
        st(16'hDEAD, 16'h0050, 2'b11, 0);
        chk("full_drop_valid", 32'(valid_Result_ls), 0);
        chk("full_drop_count", 32'(sb_count), 16);
        st(16'hBEEF, 16'h0051, 2'b11, 1);
        chk("full_acc_valid", 32'(valid_Result_ls), 1);
        chk("full_acc_count", 32'(sb_count), 16);
        ret_all();

        // flush while two entries retire
        for (int i = 0; i < 4; i++) st(16'(16'h4000 + i), 16'(16'h0040 + i), 2'b11, 0);
        step(1'b1, 1'b1, 16'h0, 16'h0040, 2'b00, 1'b1, 1'b0, 3'b011, 3'b000, 6'h3f);
        chk("flush_count", 32'(sb_count), 0);
        chk("flush_valid", 32'(valid_Result_ls), 0);
        ld(16'h0041);
        chk("flush_retired", 32'(Result_ls), 32'h00004001);
        ld(16'h0043);
        chk("flush_dropped", 32'(Result_ls), 32'h0);

        // freeze holds the result registers
        ld(16'h0040);
        step(1'b1, 1'b1, 16'h0, 16'h0021, 2'b00, 1'b0, 1'b1, 3'b000, 3'b000, 6'h00);
        chk("freeze_data", 32'(Result_ls), 32'h00004000);
        chk("freeze_valid", 32'(valid_Result_ls), 1);

        for (int i = 0; i < 500; i++) begin
            logic [2:0] r, e;
            logic [5:0] t;
            r = 3'($urandom); e = 3'($urandom_range(0, 7) == 0 ? $urandom : 0); t = 6'($urandom) | 6'h15;
            if (calc_n(r, e, t) > sbm.size()) r = '0;
            step($urandom_range(0, 3) != 0, 1'($urandom), 16'($urandom), addr_tab[$urandom_range(0, 5)],
                 2'($urandom), $urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, r, e, t);
        end

        idle_ret(0);
        idle_ret(0);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
